// File: rtl/priority_pkg.sv
// priority_pkg: constants and helpers shared by the busy-vector tracker and the
// downstream priority encoder.
//   DEFAULT_WIDTH : default number of tracked entries
//   idx_width()   : index width for a given entry count (minimum 1)
package priority_pkg;

    localparam int unsigned DEFAULT_WIDTH = 64;

    // $clog2(1) is 0, but a one-entry tracker still needs a 1-bit index port.
    function automatic int unsigned idx_width(input int unsigned width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/index_decoder.sv
// index_decoder: combinational index-to-one-hot decoder.
// Ports:
//   en   - input,  decode enable; mask is zero when low
//   idx  - input,  IDXW-bit index
//   mask - output, WIDTH-bit one-hot mask; zero when idx >= WIDTH
module index_decoder
    import priority_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned IDXW  = idx_width(WIDTH)
) (
    input  logic             en,
    input  logic [IDXW-1:0]  idx,
    output logic [WIDTH-1:0] mask
);

    // Only indices below WIDTH have a matching bit, so out-of-range indices
    // fall through to an all-zero mask.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (en && (idx == IDXW'(i))) begin
                mask[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/busy_vector_decoder.sv
// busy_vector_decoder: registered occupancy tracker with set/clear by index,
// flush, running population count and full/empty flags.
// Optional feature macro: BUSY_VECTOR_ERR_CHECK_EN enables the sticky err flag
// (set of a busy bit, clear of a free bit, or out-of-range index); when
// undefined, err is tied to 0 and no checking logic exists.
// Ports:
//   clk       - input,  clock, rising edge
//   rst       - input,  asynchronous active-high reset
//   set_valid - input,  mark entry set_idx busy
//   set_idx   - input,  IDXW-bit index to mark busy
//   clr_valid - input,  mark entry clr_idx free
//   clr_idx   - input,  IDXW-bit index to mark free
//   flush     - input,  clear all entries (wins over set/clr)
//   busy_vec  - output, registered occupancy vector
//   busy_cnt  - output, registered population count of busy_vec
//   full      - output, registered, busy_cnt == WIDTH
//   empty     - output, registered, busy_cnt == 0
//   err       - output, sticky protocol-error flag
module busy_vector_decoder
    import priority_pkg::*;
#(
    parameter  int unsigned WIDTH = DEFAULT_WIDTH,
    localparam int unsigned IDXW  = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_valid,
    input  logic [IDXW-1:0]  set_idx,
    input  logic             clr_valid,
    input  logic [IDXW-1:0]  clr_idx,
    input  logic             flush,
    output logic [WIDTH-1:0] busy_vec,
    output logic [IDXW:0]    busy_cnt,
    output logic             full,
    output logic             empty,
    output logic             err
);

    localparam int unsigned CNTW = IDXW + 1;

    logic [WIDTH-1:0] set_mask;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] vec_d;
    logic [CNTW-1:0]  cnt_d;
    logic             full_d;
    logic             empty_d;
    logic             eff_set;
    logic             eff_clr;

    index_decoder #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_set_dec (
        .en   (set_valid),
        .idx  (set_idx),
        .mask (set_mask)
    );

    index_decoder #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_clr_dec (
        .en   (clr_valid),
        .idx  (clr_idx),
        .mask (clr_mask)
    );

    always_comb begin
        // A set only counts when it turns a free bit busy; a clear only counts
        // when it frees a busy bit that is not being set in the same cycle.
        eff_set = |(set_mask & ~busy_vec);
        eff_clr = |(clr_mask & busy_vec & ~set_mask);
        vec_d   = (busy_vec & ~clr_mask) | set_mask;
        cnt_d   = busy_cnt + CNTW'(eff_set) - CNTW'(eff_clr);
        if (flush) begin
            vec_d = '0;
            cnt_d = '0;
        end
        // Flags derive from the next count so they land with busy_vec.
        full_d  = (cnt_d == CNTW'(WIDTH));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_vec <= '0;
            busy_cnt <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            busy_vec <= vec_d;
            busy_cnt <= cnt_d;
            full     <= full_d;
            empty    <= empty_d;
        end
    end

`ifdef BUSY_VECTOR_ERR_CHECK_EN
    logic set_err;
    logic clr_err;

    // A valid request with an all-zero mask means the index was out of range.
    always_comb begin
        set_err = set_valid && (~|set_mask || |(set_mask & busy_vec));
        clr_err = clr_valid && (~|clr_mask || ~|(clr_mask & busy_vec));
    end

    // Flush leaves err untouched; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (!flush && (set_err || clr_err)) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_busy_vector_decoder.sv
// Self-checking bench: drives a 64-entry and a 48-entry instance with the same
// index stimulus and compares both against a per-entry reference model.
module tb_busy_vector_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       set_valid = 1'b0;
    logic [5:0] set_idx = '0;
    logic       clr_valid = 1'b0;
    logic [5:0] clr_idx = '0;
    logic       flush = 1'b0;

    logic [63:0] a_vec;
    logic [6:0]  a_cnt;
    logic        a_full, a_empty, a_err;
    logic [47:0] b_vec;
    logic [6:0]  b_cnt;
    logic        b_full, b_empty, b_err;

    logic [63:0] m_a, m_b;
    logic        e_a, e_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    busy_vector_decoder #(.WIDTH(64)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .set_valid (set_valid),
        .set_idx   (set_idx),
        .clr_valid (clr_valid),
        .clr_idx   (clr_idx),
        .flush     (flush),
        .busy_vec  (a_vec),
        .busy_cnt  (a_cnt),
        .full      (a_full),
        .empty     (a_empty),
        .err       (a_err)
    );

    busy_vector_decoder #(.WIDTH(48)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .set_valid (set_valid),
        .set_idx   (set_idx),
        .clr_valid (clr_valid),
        .clr_idx   (clr_idx),
        .flush     (flush),
        .busy_vec  (b_vec),
        .busy_cnt  (b_cnt),
        .full      (b_full),
        .empty     (b_empty),
        .err       (b_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int popcnt(input logic [63:0] v, input int w);
        int n = 0;
        for (int i = 0; i < w; i++) n += int'(v[i]);
        return n;
    endfunction

    // Reference behaviour for one clock edge, from the request rules.
    task automatic model_step(input int w, inout logic [63:0] vec, inout logic e);
        int si = int'(set_idx);
        int ci = int'(clr_idx);
        if (flush) begin
            vec = '0;
        end else begin
`ifdef BUSY_VECTOR_ERR_CHECK_EN
            if (set_valid && (si >= w || vec[si])) e = 1'b1;
            if (clr_valid && (ci >= w || !vec[ci])) e = 1'b1;
`endif
            if (clr_valid && ci < w) vec[ci] = 1'b0;
            if (set_valid && si < w) vec[si] = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        int ca = popcnt(m_a, 64);
        int cb = popcnt(m_b, 48);
        check({tag, ".a_vec"},   a_vec, m_a);
        check({tag, ".a_cnt"},   64'(a_cnt), 64'(ca));
        check({tag, ".a_full"},  64'(a_full), 64'(ca == 64));
        check({tag, ".a_empty"}, 64'(a_empty), 64'(ca == 0));
        check({tag, ".a_err"},   64'(a_err), 64'(e_a));
        check({tag, ".b_vec"},   64'(b_vec), m_b & 64'hFFFF_FFFF_FFFF);
        check({tag, ".b_cnt"},   64'(b_cnt), 64'(cb));
        check({tag, ".b_full"},  64'(b_full), 64'(cb == 48));
        check({tag, ".b_empty"}, 64'(b_empty), 64'(cb == 0));
        check({tag, ".b_err"},   64'(b_err), 64'(e_b));
    endtask

    task automatic step(input string tag, input bit sv, input int si,
                        input bit cv, input int ci, input bit fl);
        set_valid = sv;
        set_idx   = 6'(si);
        clr_valid = cv;
        clr_idx   = 6'(ci);
        flush     = fl;
        @(posedge clk);
        #1;
        model_step(64, m_a, e_a);
        model_step(48, m_b, e_b);
        check_all(tag);
        set_valid = 1'b0;
        clr_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic model_reset();
        m_a = '0;
        m_b = '0;
        e_a = 1'b0;
        e_b = 1'b0;
    endtask

    initial begin
        model_reset();
        // Asynchronous reset seen before any clock edge.
        #2 rst = 1'b1;
        #1 check_all("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        step("idle", 0, 0, 0, 0, 0);
        step("set5", 1, 5, 0, 0, 0);
        step("set63", 1, 63, 0, 0, 0);
        check("set63.const", a_vec, 64'h8000_0000_0000_0020);
        check("set63.cnt", 64'(a_cnt), 64'd2);

        step("set7clr7", 1, 7, 1, 7, 0);
        check("set7clr7.bit", 64'(a_vec[7]), 64'd1);
        check("set7clr7.cnt", 64'(a_cnt), 64'd3);
        step("set9", 1, 9, 0, 0, 0);
        step("set3clr9", 1, 3, 1, 9, 0);
        check("set3clr9.cnt", 64'(a_cnt), 64'd4);
        step("hold", 0, 0, 0, 0, 0);

        step("clr12free", 0, 0, 1, 12, 0);
        step("flush1", 0, 0, 0, 0, 1);
`ifdef BUSY_VECTOR_ERR_CHECK_EN
        check("err.sticky", 64'(a_err), 64'd1);
`else
        check("err.tied", 64'(a_err), 64'd0);
`endif

        for (int i = 0; i < 64; i++) step("fill", 1, i, 0, 0, 0);
        check("fill.full", 64'(a_full), 64'd1);
        check("fill.cnt", 64'(a_cnt), 64'd64);
        step("flush_set", 1, 0, 0, 0, 1);
        check("flush_set.empty", 64'(a_empty), 64'd1);

        step("set50", 1, 50, 0, 0, 0);
        check("set50.b_cnt", 64'(b_cnt), 64'd0);

        for (int n = 0; n < 600; n++) begin
            step("rand", ($urandom_range(0, 1) == 1), int'($urandom_range(0, 63)),
                 ($urandom_range(0, 2) != 0), int'($urandom_range(0, 63)),
                 ($urandom_range(0, 59) == 0));
        end

        // Mid-operation reset with busy_vec = 0xFF on the 64-entry instance.
        step("pre_flush", 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) step("pre_rst", 1, i, 0, 0, 0);
        check("pre_rst.vec", a_vec, 64'hFF);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        set_valid = 1'b1;
        set_idx   = 6'd1;
        flush     = 1'b1;
        @(posedge clk);
        #1 check_all("rst_held");
        rst       = 1'b0;
        set_valid = 1'b0;
        flush     = 1'b0;
        step("post_rst", 1, 2, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/busy_vector_decoder.md
BUSY_VECTOR_DECODER -- requirements
Module: busy_vector_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 64: number of tracked entries (1..256; non-power-of-two allowed).
REQ-002 SHALL have localparam IDXW = $clog2(WIDTH): index width (1 when WIDTH=1).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port set_valid, input, 1, request to mark entry set_idx busy.
REQ-006 SHALL have port set_idx, input, IDXW, index to mark busy.
REQ-007 SHALL have port clr_valid, input, 1, request to mark entry clr_idx free.
REQ-008 SHALL have port clr_idx, input, IDXW, index to mark free.
REQ-009 SHALL have port flush, input, 1, clear all entries.
REQ-010 SHALL have port busy_vec, output, WIDTH, registered occupancy vector; bit i set = entry i busy; feeds downstream priority encoders.
REQ-011 SHALL have port busy_cnt, output, IDXW+1, registered population count of busy_vec.
REQ-012 SHALL have port full, output, 1, registered; busy_cnt == WIDTH.
REQ-013 SHALL have port empty, output, 1, registered; busy_cnt == 0.
REQ-014 SHALL have port err, output, 1, sticky protocol-error flag (see Configuration).

Function
REQ-015 SHALL decode each valid index to a one-hot WIDTH-bit mask; result visible on busy_vec one cycle after the request edge.
REQ-016 SHALL apply next_vec = (busy_vec & ~clr_mask) | set_mask; same-index set and clr in one cycle leaves bit set.
REQ-017 SHALL ignore any set_idx or clr_idx >= WIDTH (mask all-zero, no state change).
REQ-018 SHALL treat set of an already-busy bit and clr of an already-free bit as no-ops on busy_vec and busy_cnt.
REQ-019 SHALL update busy_cnt incrementally: +1 on effective set, -1 on effective clr, net 0 when both effective on different indices; never wraps.
REQ-020 SHALL give flush priority over set and clr in the same cycle: busy_vec=0, busy_cnt=0, empty=1, full=0 next cycle; err unchanged.
REQ-021 SHALL keep full, empty and busy_cnt consistent with busy_vec every cycle (no extra latency).
REQ-022 SHALL hold all state when no request or flush is active.

Reset
REQ-023 SHALL on rst assertion immediately force busy_vec=0, busy_cnt=0, empty=1, full=0, err=0, independent of clk.
REQ-024 SHALL ignore set, clr and flush while rst is high; first update on the first rising edge after deassertion.

Configuration
REQ-025 SHALL support macro BUSY_VECTOR_ERR_CHECK_EN: when defined, err sets and holds until reset on set of a busy bit, clr of a free bit, or out-of-range index with its valid high.
REQ-026 SHALL tie err to 0 when BUSY_VECTOR_ERR_CHECK_EN is undefined, with no checking logic generated; all other behaviour identical.

Structure
REQ-027 SHALL place the IDXW computation helper and shared default WIDTH constant in package priority_pkg, shared with the priority encoder.
REQ-028 SHALL use one sub-module, index_decoder (combinational: index + enable -> one-hot WIDTH mask, zero for out-of-range), instantiated twice (set, clr).

Verification (WIDTH=64)
REQ-029 SHALL cover reset: rst pulse mid-operation with busy_vec=0xFF -> outputs 0, empty=1 immediately, before next edge.
REQ-030 SHALL cover set idx 5 then idx 63 -> busy_vec=0x8000_0000_0000_0020, busy_cnt=2, one-cycle latency each.
REQ-031 SHALL cover set 7 and clr 7 same cycle from free -> bit 7 set, busy_cnt +1; set 3 + clr 9 with 9 busy -> cnt unchanged.
REQ-032 SHALL cover filling all 64 entries -> full=1, busy_cnt=64; then flush with set_valid=1 -> busy_vec=0, empty=1.
REQ-033 SHALL cover with BUSY_VECTOR_ERR_CHECK_EN: clr of free idx 12 -> err=1 next cycle, sticky through flush; without macro err stays 0.
REQ-034 SHALL cover WIDTH=48: set_idx=50 -> no change, busy_cnt unchanged, err=1 only when macro defined.
